// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Turns a valid/ready command into one APB SETUP/ACCESS transfer and reports
// completion with a one-cycle rsp_valid pulse. rsp_rdata/rsp_err hold until
// the next completion.
// Optional feature macro: APB_MASTER_TIMEOUT_EN. When it is defined, an ACCESS
// phase that waits TIMEOUT cycles with PREADY low is aborted with rsp_err=1.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_write,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLAVEERR
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_accept;
    logic                w_done;
    logic                w_timeout;
    logic [ADDR_W-1:0]   r_paddr;
    logic                r_pwrite;
    logic [DATA_W-1:0]   r_pwdata;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;

    // A zero timeout would abort every transfer on its first wait cycle.
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be at least 1");
    end

    assign w_accept = cmd_valid && (r_state == IDLE);
    assign w_done   = (r_state == ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_wait_cnt;

    // Fires on the edge that ends the TIMEOUT-th wait cycle of ACCESS.
    assign w_timeout = (r_state == ACCESS) && !PREADY &&
                       (r_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Wait-state counter: cleared when a transfer enters SETUP.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_wait_cnt <= '0;
        else if (w_accept)
            r_wait_cnt <= '0;
        else if ((r_state == ACCESS) && !PREADY)
            r_wait_cnt <= r_wait_cnt + 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register; async reset makes PSEL/PENABLE drop immediately.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Next state and APB phase outputs decoded from state.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    w_next = SETUP;
            end
            SETUP: begin
                PSEL   = 1'b1;
                w_next = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (w_done || w_timeout)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Capture the command on accept; held stable until the next accept.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_paddr  <= '0;
            r_pwrite <= 1'b0;
            r_pwdata <= '0;
        end else if (w_accept) begin
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_wdata;
        end
    end

    // Completion: pulse valid, latch data/error only on completion.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_timeout;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
                r_rsp_err   <= PSLAVEERR;
            end else if (w_timeout) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign PADDR     = r_paddr;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: stimulus pushes the expected transfer,
// a monitor checks the APB phases and pops/compares on every rsp_valid.
module tb_apb_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          PCLK, PRESETn;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr, PADDR;
    logic [DW-1:0] cmd_wdata, rsp_rdata, PWDATA, PRDATA;
    logic          rsp_valid, rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLAVEERR;

    apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLAVEERR(PSLAVEERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            nwait;      // completer wait states before PREADY
        logic [DW-1:0] prdata;
        logic          perr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_acc;    // expected ACCESS cycles
    } txn_t;

    txn_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   npsel = 0;
    int   npen = 0;
    int   wcnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completer model: PREADY after nwait ACCESS cycles; junk PRDATA and
    // PSLAVEERR=1 whenever PREADY is low, which the DUT must ignore.
    always @(posedge PCLK) begin
        #1;
        if (PSEL && PENABLE && q.size() > 0) begin
            PREADY    = (wcnt == q[0].nwait);
            PRDATA    = PREADY ? q[0].prdata : 32'hDEAD_BEEF;
            PSLAVEERR = PREADY ? q[0].perr : 1'b1;
            wcnt++;
        end else begin
            wcnt      = 0;
            PREADY    = 1'b0;
            PRDATA    = 32'hDEAD_BEEF;
            PSLAVEERR = 1'b1;
        end
    end

    // Monitor: phase counting, address stability, response compare.
    always @(negedge PCLK) begin
        txn_t t;
        cyc++;
        if (!PRESETn) begin
            npsel   = 0;
            npen    = 0;
            acc_cyc = -1;
        end else begin
            if (PSEL) begin
                npsel++;
                if (PENABLE) npen++;
                chk("cmd_ready_low_when_busy", cmd_ready, 1'b0);
                if (q.size() > 0) begin
                    chk("PADDR_stable", PADDR, q[0].addr);
                    chk("PWRITE_stable", PWRITE, q[0].wr);
                    chk("PWDATA_stable", PWDATA, q[0].wdata);
                end
            end
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp_valid: actual 1 required 0 (t=%0t)", $time);
                end else begin
                    t = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, t.exp_rdata);
                    chk("rsp_err", rsp_err, t.exp_err);
                    chk("psel_cycles", npsel, t.exp_acc + 1);
                    chk("penable_cycles", npen, t.exp_acc);
                    chk("rsp_latency", cyc - acc_cyc, t.exp_acc + 2);
                end
                npsel = 0;
                npen  = 0;
            end
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
        end
    end

    function automatic txn_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d,
                                input int nw, input logic [DW-1:0] prd, input logic pe);
        txn_t t;
        t.addr = a; t.wr = w; t.wdata = d; t.nwait = nw; t.prdata = prd; t.perr = pe;
        t.exp_rdata = w ? '0 : prd;
        t.exp_err   = pe;
        t.exp_acc   = nw + 1;
        return t;
    endfunction

    // Push expectation, present the command, return just after the accept
    // edge with cmd_valid still high.
    task automatic send(input txn_t t);
        bit ok = 0;
        q.push_back(t);
        cmd_valid = 1'b1;
        cmd_addr  = t.addr;
        cmd_write = t.wr;
        cmd_wdata = t.wdata;
        for (int i = 0; i < 100; i++) begin
            @(negedge PCLK);
            if (cmd_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout: actual 0 required 1");
        end
        @(posedge PCLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge PCLK);
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: actual %0d required 0", q.size());
            q.delete();
        end
        @(posedge PCLK);
        #1;
    endtask

    initial begin
        txn_t t;
        bit   seen;
        PRESETn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLAVEERR = 1'b0;
        repeat (2) @(negedge PCLK);
        chk("rst_PSEL", PSEL, 0);         chk("rst_PENABLE", PENABLE, 0);
        chk("rst_PADDR", PADDR, 0);       chk("rst_PWRITE", PWRITE, 0);
        chk("rst_PWDATA", PWDATA, 0);     chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // Zero-wait write.
        send(mk(32'h4, 1'b1, 32'h4, 0, 32'h0, 1'b0));
        cmd_valid = 1'b0;
        drain();

        // Read with 3 wait states, then check the response holds.
        send(mk(32'h0, 1'b0, 32'hA5, 3, 32'h8, 1'b0));
        cmd_valid = 1'b0;
        drain();
        repeat (3) @(negedge PCLK);
        chk("rsp_rdata_hold", rsp_rdata, 32'h8);
        chk("rsp_valid_single", rsp_valid, 0);
        @(posedge PCLK); #1;

        // Write with slave error.
        send(mk(32'hC, 1'b1, 32'h1, 0, 32'h0, 1'b1));
        cmd_valid = 1'b0;
        drain();

        // Back-to-back writes with cmd_valid held high.
        send(mk(32'h4, 1'b1, 32'h11, 0, 32'h0, 1'b0));
        send(mk(32'h0, 1'b1, 32'h22, 0, 32'h0, 1'b0));
        send(mk(32'h8, 1'b1, 32'h33, 0, 32'h0, 1'b0));
        send(mk(32'hC, 1'b1, 32'h44, 0, 32'h0, 1'b0));
        cmd_valid = 1'b0;
        drain();

        // Long wait: aborts with the timeout feature, waits otherwise.
        t = mk(32'h20, 1'b0, 32'h0, 25, 32'h55, 1'b0);
`ifdef APB_MASTER_TIMEOUT_EN
        t.exp_rdata = '0;
        t.exp_err   = 1'b1;
        t.exp_acc   = TO;
`endif
        send(t);
        cmd_valid = 1'b0;
        repeat (19) @(negedge PCLK);
`ifdef APB_MASTER_TIMEOUT_EN
        chk("psel_after_timeout", PSEL, 0);
`else
        chk("psel_waits_no_timeout", PSEL, 1);
`endif
        drain();

        // Reset during ACCESS: immediate abort, no response.
        send(mk(32'h30, 1'b0, 32'h0, 1000, 32'h77, 1'b0));
        cmd_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge PCLK);
            if (PENABLE) begin seen = 1; break; end
        end
        chk("reached_access", seen, 1);
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        chk("abort_PSEL", PSEL, 0);
        chk("abort_PENABLE", PENABLE, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        q.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) begin
            @(negedge PCLK);
            chk("post_rst_cmd_ready", cmd_ready, 1);
            chk("post_rst_rsp_valid", rsp_valid, 0);
        end
        @(posedge PCLK); #1;

        // Normal operation after the abort.
        send(mk(32'h8, 1'b0, 32'h0, 2, 32'h1234, 1'b0));
        cmd_valid = 1'b0;
        drain();

        repeat (2) @(negedge PCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
